uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rr_pick.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 83 ++++++++
 tb/tb_uart_tx_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and sizing for the UART transmit arbiter.
package uart_pkg;
  localparam int NUM_REQ  = 4;
  localparam int BYTE_W   = 8;
  localparam int PERIOD_W = 20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_BUSY,
    S_GAP
  } state_t;
endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority encoder: first set request at or above i_Ptr, wrapping mod NUM_REQ.
module uart_rr_pick
  import uart_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_Req,
  input  logic [1:0]         i_Ptr,
  output logic               o_Valid,
  output logic [1:0]         o_Idx
);
  logic [1:0] w_Pos;

  // Scan from the farthest slot back to i_Ptr so the nearest hit wins last.
  always_comb begin
    o_Valid = 1'b0;
    o_Idx   = i_Ptr;
    w_Pos   = i_Ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_Pos = i_Ptr + 2'(k);
      if (i_Req[w_Pos]) begin
        o_Valid = 1'b1;
        o_Idx   = w_Pos;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding four byte requesters into one UART transmitter,
// with a one-bit-time guard between frames. UART_ARB_PRIO0_EN gives requester 0 fixed priority.
module uart_tx_arbiter
  import uart_pkg::*;
(
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  input  logic [NUM_REQ-1:0]        i_Req,
  input  logic [NUM_REQ*BYTE_W-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]        o_Ack,
  input  logic [PERIOD_W-1:0]       i_Period,
  output logic                      o_TX_DV,
  output logic [BYTE_W-1:0]         o_TX_Byte,
  input  logic                      i_TX_Done,
  output logic                      o_Busy,
  output logic [1:0]                o_Grant_Idx
);
  state_t              r_State, w_Next;
  logic [1:0]          r_Ptr;
  logic [PERIOD_W-1:0] r_Guard;
  logic [PERIOD_W-1:0] w_Gap_Len;
  logic                w_Pick_Vld, w_Win_Vld, w_Ptr_Upd, w_Grant;
  logic [1:0]          w_Pick_Idx, w_Win_Idx;

  uart_rr_pick u_pick (
    .i_Req   (i_Req),
    .i_Ptr   (r_Ptr),
    .o_Valid (w_Pick_Vld),
    .o_Idx   (w_Pick_Idx)
  );

`ifdef UART_ARB_PRIO0_EN
  // Requester 0 bypasses rotation and leaves the pointer untouched.
  assign w_Win_Vld = i_Req[0] | w_Pick_Vld;
  assign w_Win_Idx = i_Req[0] ? 2'd0 : w_Pick_Idx;
  assign w_Ptr_Upd = ~i_Req[0];
`else
  assign w_Win_Vld = w_Pick_Vld;
  assign w_Win_Idx = w_Pick_Idx;
  assign w_Ptr_Upd = 1'b1;
`endif

  // Ack is combinational so it lands in the grant cycle; reset masks it immediately.
  assign w_Grant   = i_Rst_L && (r_State == S_IDLE) && w_Win_Vld;
  assign o_Ack     = w_Grant ? (NUM_REQ'(1) << w_Win_Idx) : '0;
  assign o_TX_DV   = (r_State == S_LOAD);
  assign o_Busy    = (r_State != S_IDLE);
  assign w_Gap_Len = (i_Period == '0) ? PERIOD_W'(1) : i_Period;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_State <= S_IDLE;
    else          r_State <= w_Next;
  end

  always_comb begin
    w_Next = r_State;
    case (r_State)
      S_IDLE: if (w_Grant) w_Next = S_LOAD;
      S_LOAD: w_Next = S_BUSY;
      S_BUSY: if (i_TX_Done) w_Next = S_GAP;
      S_GAP:  if (r_Guard <= PERIOD_W'(1)) w_Next = S_IDLE;
      default: w_Next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Ptr       <= '0;
      r_Guard     <= '0;
      o_TX_Byte   <= '0;
      o_Grant_Idx <= '0;
    end else begin
      if (w_Grant) begin
        o_TX_Byte   <= i_Req_Byte[{w_Win_Idx, 3'b000} +: BYTE_W];
        o_Grant_Idx <= w_Win_Idx;
        if (w_Ptr_Upd) r_Ptr <= w_Win_Idx + 2'd1;
      end
      // Guard length is latched on GAP entry; later period changes wait a frame.
      if (r_State == S_BUSY && i_TX_Done) r_Guard <= w_Gap_Len;
      else if (r_State == S_GAP)          r_Guard <= r_Guard - PERIOD_W'(1);
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (default build): scoreboard of expected grants checked at each o_TX_DV.
module tb_uart_tx_arbiter;
  logic        i_Clk;
  logic        i_Rst_L;
  logic [3:0]  i_Req;
  logic [31:0] i_Req_Byte;
  logic [3:0]  o_Ack;
  logic [19:0] i_Period;
  logic        o_TX_DV;
  logic [7:0]  o_TX_Byte;
  logic        i_TX_Done;
  logic        o_Busy;
  logic [1:0]  o_Grant_Idx;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] byt;
  } exp_t;

  exp_t q[$];
  int   n_cmp, n_err, n_dv, n_grant;

  uart_tx_arbiter dut (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Req       (i_Req),
    .i_Req_Byte  (i_Req_Byte),
    .o_Ack       (o_Ack),
    .i_Period    (i_Period),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .i_TX_Done   (i_TX_Done),
    .o_Busy      (o_Busy),
    .o_Grant_Idx (o_Grant_Idx)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  always @(negedge i_Clk) if (o_TX_DV === 1'b1) n_dv++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered in IDLE between edges; leaves at the negedge of the first BUSY cycle.
  task automatic grant(input logic [3:0] req, input int exp_idx, input logic [3:0] hold);
    logic [3:0] a;
    exp_t e;
    i_Req = req;
    #1;
    a = 4'b0001 << exp_idx;
    chk("ack_grant", o_Ack, a);
    e.idx = exp_idx[1:0];
    e.byt = i_Req_Byte[8*exp_idx +: 8];
    q.push_back(e);
    n_grant++;
    @(posedge i_Clk); #1;
    i_Req = req & ~a;
    @(negedge i_Clk);
    chk("tx_dv", o_TX_DV, 1);
    chk("sb_depth", q.size(), 1);
    e = q.pop_front();
    chk("grant_idx", o_Grant_Idx, e.idx);
    chk("tx_byte", o_TX_Byte, e.byt);
    chk("ack_load", o_Ack, 0);
    @(posedge i_Clk); #1;
    i_Req = hold;
    @(negedge i_Clk);
    chk("busy", o_Busy, 1);
    chk("dv_busy", o_TX_DV, 0);
    chk("ack_busy", o_Ack, 0);
  endtask

  // Pulses i_TX_Done in BUSY and measures the guard length; leaves at negedge of first IDLE cycle.
  task automatic finish_frame(input int exp_gap, input logic [19:0] new_period);
    int cnt;
    i_TX_Done = 1'b1;
    @(posedge i_Clk); #1;
    i_TX_Done = 1'b0;
    i_Period  = new_period;
    cnt = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge i_Clk);
      if (!o_Busy) break;
      cnt++;
    end
    chk("gap_len", cnt, exp_gap);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_dv = 0; n_grant = 0;
    i_Rst_L = 1'b0; i_Req = '0; i_TX_Done = 1'b0; i_Period = 20'd2;
    i_Req_Byte = 32'h000000AA;
    #1;
    chk("rst_ack", o_Ack, 0);
    chk("rst_dv", o_TX_DV, 0);
    chk("rst_byte", o_TX_Byte, 0);
    chk("rst_busy", o_Busy, 0);
    chk("rst_idx", o_Grant_Idx, 0);
    @(posedge i_Clk); #1; i_Rst_L = 1'b1;
    @(negedge i_Clk);

    // First grant, byte AA, guard of 2
    grant(4'b0001, 0, 4'b0000);
    finish_frame(2, 20'd2);

    // Fresh pointer, all four requesting: 0,1,2,3,0
    i_Rst_L = 1'b0; #1;
    chk("rst2_busy", o_Busy, 0);
    @(posedge i_Clk); #1; i_Rst_L = 1'b1;
    @(negedge i_Clk);
    i_Req_Byte = 32'h44332211;
    grant(4'b1111, 0, 4'b1111); finish_frame(2, 20'd2);
    grant(4'b1111, 1, 4'b1111); finish_frame(2, 20'd2);
    grant(4'b1111, 2, 4'b1111); finish_frame(2, 20'd2);
    grant(4'b1111, 3, 4'b1111); finish_frame(2, 20'd2);
    grant(4'b1111, 0, 4'b0000); finish_frame(2, 20'd2);

    // Guard of 5, with a period change mid-gap that must not shorten it
    i_Period = 20'd5;
    grant(4'b0100, 2, 4'b0000);
    finish_frame(5, 20'd1);

    // Pointer at 3, requests 3 and 0: wrap; period 0 gives a single guard cycle
    i_Period = 20'd0;
    grant(4'b1001, 3, 4'b1001); finish_frame(1, 20'd0);
    grant(4'b1001, 0, 4'b0000); finish_frame(1, 20'd0);

    // Stray done in IDLE, then a short request blip during BUSY
    i_TX_Done = 1'b1; #1;
    chk("idle_done_busy", o_Busy, 0);
    @(posedge i_Clk); #1; i_TX_Done = 1'b0;
    @(negedge i_Clk);
    chk("idle_done_busy2", o_Busy, 0);
    chk("idle_done_ack", o_Ack, 0);
    grant(4'b0010, 1, 4'b0000);
    i_Req = 4'b1111; #1;
    chk("blip_ack", o_Ack, 0);
    @(posedge i_Clk); #1; i_Req = 4'b0000;
    @(negedge i_Clk);
    chk("blip_busy", o_Busy, 1);
    chk("blip_dv", o_TX_DV, 0);
    finish_frame(1, 20'd0);
    chk("post_blip_ack", o_Ack, 0);
    chk("byte_held", o_TX_Byte, 8'h22);

    // Reset in BUSY: outputs clear before any edge, next grant scans from 0
    grant(4'b0010, 1, 4'b0000);
    i_Rst_L = 1'b0; #1;
    chk("arst_busy", o_Busy, 0);
    chk("arst_byte", o_TX_Byte, 0);
    chk("arst_idx", o_Grant_Idx, 0);
    chk("arst_dv", o_TX_DV, 0);
    chk("arst_ack", o_Ack, 0);
    @(posedge i_Clk); #1; i_Rst_L = 1'b1;
    @(negedge i_Clk);
    grant(4'b0110, 1, 4'b0000);
    finish_frame(1, 20'd0);

    chk("dv_count", n_dv, n_grant);
    chk("sb_left", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end
endmodule
